// File: rtl/uart_rx.sv
// UART receiver: deframes start, WIDTH data bits (LSB first), optional parity
// and stop from an oversampled serial line. Each bit is decided by a 3-sample
// majority vote around mid-bit. Results are reported as one-cycle pulses.
module uart_rx #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned PRESC_W = 6
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RX_IN,
    input  logic               PAR_EN,
    input  logic               PAR_TYP,
    input  logic [PRESC_W-1:0] Prescale,
    output logic [WIDTH-1:0]   P_DATA,
    output logic               DATA_VALID,
    output logic               PAR_ERR,
    output logic               STP_ERR
);

    localparam int unsigned BitCntW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e               state_q, state_d;
    logic [PRESC_W-1:0]   edge_cnt_q, edge_cnt_d;
    logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0]     shift_q, shift_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic                 par_en_q, par_en_d;
    logic                 par_typ_q, par_typ_d;
    logic                 par_bad_q, par_bad_d;
    logic [2:0]           smp_q, smp_d;
    logic [WIDTH-1:0]     p_data_q, p_data_d;
    logic                 data_valid_q, data_valid_d;
    logic                 par_err_q, par_err_d;
    logic                 stp_err_q, stp_err_d;

    // Sample/decision points relative to the frame's own prescale.
    logic [PRESC_W-1:0] half;
    logic               smp0_hit, smp1_hit, smp2_hit, decide, wrap;
    logic               maj;

    // Decode edge-counter positions and form the majority of the three samples.
    always_comb begin
        half     = presc_q >> 1;
        smp0_hit = (edge_cnt_q == half - PRESC_W'(1));
        smp1_hit = (edge_cnt_q == half);
        smp2_hit = (edge_cnt_q == half + PRESC_W'(1));
        decide   = (edge_cnt_q == half + PRESC_W'(2));
        wrap     = (edge_cnt_q == presc_q - PRESC_W'(1));
        maj      = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);
    end

    // Next-state logic: frame FSM, counters, sampling and result pulses.
    always_comb begin
        state_d      = state_q;
        edge_cnt_d   = edge_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        presc_d      = presc_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        par_bad_d    = par_bad_q;
        smp_d        = smp_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;

        // Edge counter free-runs over one bit period in every active state.
        if (state_q == StIdle) begin
            edge_cnt_d = '0;
        end else begin
            edge_cnt_d = wrap ? '0 : edge_cnt_q + PRESC_W'(1);
            if (smp0_hit) smp_d[0] = RX_IN;
            if (smp1_hit) smp_d[1] = RX_IN;
            if (smp2_hit) smp_d[2] = RX_IN;
        end

        case (state_q)
            StIdle: begin
                if (!RX_IN) begin
                    // Configuration is frozen for the whole frame here.
                    state_d   = StStart;
                    presc_d   = Prescale;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                    bit_cnt_d = '0;
                    par_bad_d = 1'b0;
                end
            end
            StStart: begin
                if (decide && maj) begin
                    // Start bit did not hold low through mid-bit: glitch.
                    state_d    = StIdle;
                    edge_cnt_d = '0;
                end else if (wrap) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (decide) begin
                    shift_d = (shift_q >> 1) | (WIDTH'(maj) << (WIDTH - 1));
                end
                if (wrap) begin
                    if (bit_cnt_q == BitCntW'(WIDTH - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? StParity : StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BitCntW'(1);
                    end
                end
            end
            StParity: begin
                if (decide) begin
                    par_bad_d = (maj != ((^shift_q) ^ par_typ_q));
                end
                if (wrap) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                // Leave at mid-stop so the next start edge is caught early.
                if (decide) begin
                    state_d    = StIdle;
                    edge_cnt_d = '0;
                    if (!maj) begin
                        stp_err_d = 1'b1;
                    end else if (par_bad_q) begin
                        par_err_d = 1'b1;
                    end else begin
                        p_data_d     = shift_q;
                        data_valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d    = StIdle;
                edge_cnt_d = '0;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= StIdle;
            edge_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            presc_q      <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            par_bad_q    <= 1'b0;
            smp_q        <= '0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            edge_cnt_q   <= edge_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            presc_q      <= presc_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            par_bad_q    <= par_bad_d;
            smp_q        <= smp_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
        end
    end

    assign P_DATA     = p_data_q;
    assign DATA_VALID = data_valid_q;
    assign PAR_ERR    = par_err_q;
    assign STP_ERR    = stp_err_q;

endmodule
